// File: rtl/vga_pkg.sv
`default_nettype none
//======================================================================
// Package  : vga_pkg
// Brief    : Shared VGA pipeline constants and the tile-RAM fill states.
// Revision : 1.0
//======================================================================
package vga_pkg;

    localparam int PIX_W       = 12;
    localparam int TILE_DIM    = 16;
    localparam int TILE_RAM_AW = 12;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fill_state_t;

endpackage
`default_nettype wire

// File: rtl/vga_tile_ram_if.sv
`default_nettype none
//======================================================================
// Interface : vga_tile_ram_if
// Brief     : Fill, write and read bus between loader/fetch and tile RAM.
// Revision  : 1.0
//======================================================================
interface vga_tile_ram_if #(
    parameter int DATA_W = vga_pkg::PIX_W,
    parameter int ADDR_W = vga_pkg::TILE_RAM_AW
);
    logic              fill_req;
    logic [DATA_W-1:0] fill_data;
    logic              busy;
    logic              wr_valid;
    logic              wr_ready;
    logic              wr_auto;
    logic              wr_first;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    modport master (
        output fill_req, fill_data, wr_valid, wr_auto, wr_first, wr_addr, wr_data,
               rd_en, rd_addr,
        input  busy, wr_ready, rd_data, rd_valid
    );

    modport slave (
        input  fill_req, fill_data, wr_valid, wr_auto, wr_first, wr_addr, wr_data,
               rd_en, rd_addr,
        output busy, wr_ready, rd_data, rd_valid
    );
endinterface
`default_nettype wire

// File: rtl/vga_tile_ram_core.sv
`default_nettype none
//======================================================================
// Module   : vga_tile_ram_core
// Brief    : Plain 1W/1R sync-read array, read-first on address collision.
// Revision : 1.0
//======================================================================
module vga_tile_ram_core
    import vga_pkg::*;
#(
    parameter int DATA_W = PIX_W,
    parameter int ADDR_W = TILE_RAM_AW
) (
    input  wire logic              clk,
    input  wire logic              i_we,
    input  wire logic [ADDR_W-1:0] i_waddr,
    input  wire logic [DATA_W-1:0] i_wdata,
    input  wire logic              i_re,
    input  wire logic [ADDR_W-1:0] i_raddr,
    output logic      [DATA_W-1:0] o_rdata
);
    localparam int c_depth = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [c_depth];

    // No reset on the array or read register so this maps onto RAM primitives.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) o_rdata <= r_mem[i_raddr];
    end
endmodule
`default_nettype wire

// File: rtl/vga_tile_ram.sv
`default_nettype none
//======================================================================
// Module   : vga_tile_ram
// Brief    : Tile pixel store with streaming write port, fill engine and
//            1- or 2-cycle read pipeline.
// Revision : 1.0
//======================================================================
module vga_tile_ram
    import vga_pkg::*;
#(
    parameter int               DATA_W        = PIX_W,
    parameter int               ADDR_W        = TILE_RAM_AW,
    parameter int               RD_LAT        = 1,
    parameter bit               FILL_ON_RESET = 1'b1,
    parameter logic [DATA_W-1:0] FILL_VALUE   = '0
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    vga_tile_ram_if.slave   bus
);
    localparam fill_state_t       c_rst_state = FILL_ON_RESET ? ST_FILL : ST_IDLE;
    localparam logic [ADDR_W-1:0] c_last_addr = '1;

    fill_state_t       r_state;
    fill_state_t       w_state_nxt;
    logic              w_idle;
    logic              w_busy;
    logic              w_fill_acc;
    logic              w_wr_acc;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_fill_cnt;
    logic [DATA_W-1:0] r_fill_word;
    logic [ADDR_W-1:0] w_wr_addr;
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_ram_data;
    logic [DATA_W-1:0] w_core_rdata;

    assign w_idle       = (r_state == ST_IDLE);
    assign w_busy       = (r_state == ST_FILL);
    assign bus.busy     = w_busy;
    assign bus.wr_ready = w_idle;

    // A fill request in the same cycle as a write beat takes priority.
    assign w_fill_acc = w_idle & bus.fill_req;
    assign w_wr_acc   = w_idle & bus.wr_valid & ~bus.fill_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_rst_state;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_fill_acc) w_state_nxt = ST_FILL;
            ST_FILL: if (r_fill_cnt == c_last_addr) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill_cnt  <= '0;
            r_fill_word <= FILL_VALUE;
        end else if (w_fill_acc) begin
            r_fill_cnt  <= '0;
            r_fill_word <= bus.fill_data;
        end else if (w_busy) begin
            r_fill_cnt  <= r_fill_cnt + ADDR_W'(1);
        end
    end

    assign w_wr_addr = (bus.wr_auto && !bus.wr_first) ? r_ptr : bus.wr_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      r_ptr <= '0;
        else if (w_wr_acc && bus.wr_auto) r_ptr <= w_wr_addr + ADDR_W'(1);
    end

    assign w_ram_we   = w_busy | w_wr_acc;
    assign w_ram_addr = w_busy ? r_fill_cnt  : w_wr_addr;
    assign w_ram_data = w_busy ? r_fill_word : bus.wr_data;

    vga_tile_ram_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_addr),
        .i_wdata (w_ram_data),
        .i_re    (bus.rd_en),
        .i_raddr (bus.rd_addr),
        .o_rdata (w_core_rdata)
    );

    generate
        if (RD_LAT == 1) begin : g_lat1
            logic r_vld;
            logic r_rd_seen;

            // The core register has no reset; mask it to zero until a read lands.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld     <= 1'b0;
                    r_rd_seen <= 1'b0;
                end else begin
                    r_vld <= bus.rd_en;
                    if (bus.rd_en) r_rd_seen <= 1'b1;
                end
            end

            assign bus.rd_data  = r_rd_seen ? w_core_rdata : '0;
            assign bus.rd_valid = r_vld;
        end else begin : g_lat2
            logic [1:0]        r_vld;
            logic [DATA_W-1:0] r_rd_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld  <= '0;
                    r_rd_q <= '0;
                end else begin
                    r_vld <= {r_vld[0], bus.rd_en};
                    if (r_vld[0]) r_rd_q <= w_core_rdata;
                end
            end

            assign bus.rd_data  = r_rd_q;
            assign bus.rd_valid = r_vld[1];
        end
    endgenerate
endmodule
`default_nettype wire

// File: tb/tb_vga_tile_ram.sv
`default_nettype none
//======================================================================
// Module   : tb_vga_tile_ram
// Brief    : Directed self-checking bench for vga_tile_ram (RD_LAT 1 and 2).
// Revision : 1.0
//======================================================================
module tb_vga_tile_ram;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    vga_tile_ram_if #(.DATA_W(12), .ADDR_W(12)) bus1 ();
    vga_tile_ram_if #(.DATA_W(12), .ADDR_W(12)) bus2 ();

    vga_tile_ram #(
        .DATA_W(12), .ADDR_W(12), .RD_LAT(1),
        .FILL_ON_RESET(1'b1), .FILL_VALUE(12'h000)
    ) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    vga_tile_ram #(
        .DATA_W(12), .ADDR_W(12), .RD_LAT(2),
        .FILL_ON_RESET(1'b0), .FILL_VALUE(12'h000)
    ) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus1.fill_req = 0; bus1.fill_data = '0; bus1.wr_valid = 0; bus1.wr_auto = 0;
        bus1.wr_first = 0; bus1.wr_addr = '0;   bus1.wr_data = '0;  bus1.rd_en = 0;
        bus1.rd_addr = '0;
        bus2.fill_req = 0; bus2.fill_data = '0; bus2.wr_valid = 0; bus2.wr_auto = 0;
        bus2.wr_first = 0; bus2.wr_addr = '0;   bus2.wr_data = '0;  bus2.rd_en = 0;
        bus2.rd_addr = '0;
    endtask

    task automatic wr1(input logic auto_m, input logic first,
                       input logic [11:0] a, input logic [11:0] d);
        bus1.wr_valid = 1; bus1.wr_auto = auto_m; bus1.wr_first = first;
        bus1.wr_addr = a;  bus1.wr_data = d;
        tick;
        bus1.wr_valid = 0; bus1.wr_auto = 0; bus1.wr_first = 0;
    endtask

    task automatic rd1(input logic [11:0] a, output logic [11:0] d, output logic v);
        bus1.rd_en = 1; bus1.rd_addr = a;
        tick;
        d = bus1.rd_data; v = bus1.rd_valid;
        bus1.rd_en = 0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst_n = 0;
        #23;
        checks++; if (bus1.busy !== 1'b1) begin errors++; $display("FAIL reset_busy1: got %b expected 1", bus1.busy); end
        checks++; if (bus1.wr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready1: got %b expected 0", bus1.wr_ready); end
        checks++; if (bus1.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rdvalid1: got %b expected 0", bus1.rd_valid); end
        checks++; if (bus1.rd_data !== 12'h000) begin errors++; $display("FAIL reset_rddata1: got %h expected 000", bus1.rd_data); end
        checks++; if (bus2.busy !== 1'b0) begin errors++; $display("FAIL reset_busy2: got %b expected 0", bus2.busy); end
        checks++; if (bus2.wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready2: got %b expected 1", bus2.wr_ready); end
        checks++; if (bus2.rd_data !== 12'h000) begin errors++; $display("FAIL reset_rddata2: got %h expected 000", bus2.rd_data); end
    endtask

    task automatic count_fill(input string name, input logic pulse_mid);
        int   n = 0;
        logic ready_seen = 0;
        while (bus1.busy && n < 5000) begin
            if (bus1.wr_ready) ready_seen = 1;
            if (pulse_mid && n == 10) begin bus1.fill_req = 1; bus1.fill_data = 12'h0F0; end
            tick;
            bus1.fill_req = 0;
            n++;
        end
        checks++; if (n != 4096) begin errors++; $display("FAIL %s_len: got %0d cycles expected 4096", name, n); end
        checks++; if (ready_seen !== 1'b0) begin errors++; $display("FAIL %s_ready: got wr_ready=1 during fill expected 0", name); end
        checks++; if (bus1.wr_ready !== 1'b1) begin errors++; $display("FAIL %s_ready_after: got %b expected 1", name, bus1.wr_ready); end
    endtask

    task automatic test_reset_fill;
        logic [11:0] addrs [3] = '{12'h000, 12'h7FF, 12'hFFF};
        logic [11:0] d;
        logic        v;
        @(posedge clk); #1;
        rst_n = 1;
        count_fill("reset_fill", 1'b0);
        for (int i = 0; i < 3; i++) begin
            rd1(addrs[i], d, v);
            checks++; if (d !== 12'h000 || v !== 1'b1) begin errors++; $display("FAIL reset_fill_rd[%h]: got %h/%b expected 000/1", addrs[i], d, v); end
        end
    endtask

    task automatic test_auto_burst;
        logic [11:0] addrs [5] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001, 12'h002};
        logic [11:0] data  [5] = '{12'hA01, 12'hB02, 12'hC03, 12'hD04, 12'hE05};
        logic [11:0] d;
        logic        v;
        wr1(1, 1, 12'hFFE, data[0]);
        for (int i = 1; i < 5; i++) wr1(1, 0, 12'h555, data[i]);
        for (int i = 0; i < 5; i++) begin
            rd1(addrs[i], d, v);
            checks++; if (d !== data[i] || v !== 1'b1) begin errors++; $display("FAIL burst_rd[%h]: got %h/%b expected %h/1", addrs[i], d, v, data[i]); end
        end
    endtask

    task automatic test_direct;
        logic [11:0] d;
        logic        v;
        wr1(0, 0, 12'h123, 12'hF0F);
        rd1(12'h123, d, v);
        checks++; if (d !== 12'hF0F || v !== 1'b1) begin errors++; $display("FAIL direct1_rd: got %h/%b expected f0f/1", d, v); end
        tick;
        checks++; if (bus1.rd_valid !== 1'b0 || bus1.rd_data !== 12'hF0F) begin errors++; $display("FAIL direct1_hold: got %h/%b expected f0f/0", bus1.rd_data, bus1.rd_valid); end

        bus2.wr_valid = 1; bus2.wr_addr = 12'h123; bus2.wr_data = 12'hF0F;
        tick;
        bus2.wr_valid = 0;
        bus2.rd_en = 1; bus2.rd_addr = 12'h123;
        tick;
        bus2.rd_en = 0;
        checks++; if (bus2.rd_valid !== 1'b0 || bus2.rd_data !== 12'h000) begin errors++; $display("FAIL direct2_lat1: got %h/%b expected 000/0", bus2.rd_data, bus2.rd_valid); end
        tick;
        checks++; if (bus2.rd_valid !== 1'b1 || bus2.rd_data !== 12'hF0F) begin errors++; $display("FAIL direct2_lat2: got %h/%b expected f0f/1", bus2.rd_data, bus2.rd_valid); end
        tick;
        checks++; if (bus2.rd_valid !== 1'b0 || bus2.rd_data !== 12'hF0F) begin errors++; $display("FAIL direct2_hold: got %h/%b expected f0f/0", bus2.rd_data, bus2.rd_valid); end
    endtask

    task automatic test_collision;
        logic [11:0] d;
        logic        v;
        wr1(0, 0, 12'h010, 12'h111);
        bus1.wr_valid = 1; bus1.wr_addr = 12'h010; bus1.wr_data = 12'hABC;
        bus1.rd_en = 1;    bus1.rd_addr = 12'h010;
        tick;
        bus1.wr_valid = 0; bus1.rd_en = 0;
        checks++; if (bus1.rd_data !== 12'h111) begin errors++; $display("FAIL collision_old: got %h expected 111", bus1.rd_data); end
        rd1(12'h010, d, v);
        checks++; if (d !== 12'hABC) begin errors++; $display("FAIL collision_new: got %h expected abc", d); end
    endtask

    task automatic test_fill_req;
        logic [11:0] addrs [5] = '{12'h201, 12'h000, 12'h7FF, 12'hFFF, 12'h123};
        logic [11:0] d;
        logic        v;
        bus1.fill_req = 1; bus1.fill_data = 12'h00F;
        bus1.wr_valid = 1; bus1.wr_auto = 1; bus1.wr_first = 1;
        bus1.wr_addr = 12'h200; bus1.wr_data = 12'h777;
        tick;
        bus1.fill_req = 0; bus1.wr_valid = 0; bus1.wr_auto = 0; bus1.wr_first = 0;
        checks++; if (bus1.busy !== 1'b1 || bus1.wr_ready !== 1'b0) begin errors++; $display("FAIL fill_start: got busy=%b ready=%b expected 1/0", bus1.busy, bus1.wr_ready); end
        count_fill("req_fill", 1'b1);
        // Pointer was 003 after the burst; a wrongly accepted beat would have moved it to 201.
        wr1(1, 0, 12'h000, 12'h5A5);
        rd1(12'h003, d, v);
        checks++; if (d !== 12'h5A5) begin errors++; $display("FAIL fill_ptr: got %h expected 5a5", d); end
        for (int i = 0; i < 5; i++) begin
            rd1(addrs[i], d, v);
            checks++; if (d !== 12'h00F) begin errors++; $display("FAIL fill_rd[%h]: got %h expected 00f", addrs[i], d); end
        end
    endtask

    task automatic test_reset_mid_fill;
        logic [11:0] d;
        logic        v;
        bus1.fill_req = 1; bus1.fill_data = 12'h0AA;
        tick;
        bus1.fill_req = 0;
        repeat (99) tick;
        bus1.rd_en = 1; bus1.rd_addr = 12'h000;
        tick;
        bus1.rd_en = 0;
        checks++; if (bus1.rd_valid !== 1'b1 || bus1.rd_data !== 12'h0AA || bus1.busy !== 1'b1) begin errors++; $display("FAIL midfill_pre: got %h/%b busy=%b expected 0aa/1 busy=1", bus1.rd_data, bus1.rd_valid, bus1.busy); end
        #2 rst_n = 0;
        #1;
        checks++; if (bus1.rd_valid !== 1'b0 || bus1.rd_data !== 12'h000) begin errors++; $display("FAIL midfill_async: got %h/%b expected 000/0", bus1.rd_data, bus1.rd_valid); end
        checks++; if (bus1.busy !== 1'b1 || bus1.wr_ready !== 1'b0) begin errors++; $display("FAIL midfill_state: got busy=%b ready=%b expected 1/0", bus1.busy, bus1.wr_ready); end
        tick; tick;
        rst_n = 1;
        count_fill("refill", 1'b0);
        rd1(12'h000, d, v);
        checks++; if (d !== 12'h000) begin errors++; $display("FAIL refill_rd0: got %h expected 000", d); end
        rd1(12'hFFF, d, v);
        checks++; if (d !== 12'h000) begin errors++; $display("FAIL refill_rdfff: got %h expected 000", d); end
    endtask

    initial begin
        test_reset();
        test_reset_fill();
        test_auto_burst();
        test_direct();
        test_collision();
        test_fill_req();
        test_reset_mid_fill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/vga_tile_ram.md
Name: vga_tile_ram

Overview:
Parametrised tile/sprite pixel store for the VGA pipeline, holding 12bpp tile pixels (default 16 tiles of 16x16 pixels). It adds three things to a plain sync-read RAM:
- a valid/ready write port with an auto-incrementing address pointer, so the CPU/loader can stream tiles;
- a hardware fill engine that clears or paints the whole array;
- a configurable read-pipeline latency for timing closure against the pixel fetch path.
Sits between the tile loader (write side) and the VGA pixel fetch unit (read side).

Parameters:
DATA_W, 12, pixel word width (bits).
ADDR_W, 12, address width; DEPTH = 2**ADDR_W words.
RD_LAT, 1, read latency in cycles; legal values 1 or 2.
FILL_ON_RESET, 1, 1 = start a fill with FILL_VALUE when reset is released.
FILL_VALUE, 0, fill word used by the reset-triggered fill.

Ports:
clk  in  1  single clock, all logic rising-edge.
rst_n  in  1  asynchronous, active-low reset.
fill_req  in  1  one-cycle pulse: fill the whole array with fill_data.
fill_data  in  DATA_W  fill word, sampled when fill_req is accepted.
busy  out  1  fill engine active.
wr_valid  in  1  write request.
wr_ready  out  1  write accepted when wr_valid & wr_ready.
wr_auto  in  1  1 = use the internal pointer; 0 = use wr_addr.
wr_first  in  1  with wr_auto=1: load the pointer from wr_addr for this beat.
wr_addr  in  ADDR_W  write address (direct mode, or pointer seed).
wr_data  in  DATA_W  write data.
rd_en  in  1  read request.
rd_addr  in  ADDR_W  read address.
rd_data  out  DATA_W  read data.
rd_valid  out  1  rd_data valid, RD_LAT cycles after rd_en.

Behaviour:
- Reset values: rd_data=0, rd_valid=0, wr_ready=!FILL_ON_RESET, busy=FILL_ON_RESET, write pointer=0, fill counter=0. Array contents are not reset.
- FSM states:
  - IDLE -> FILL on an accepted fill_req.
  - FILL -> IDLE after writing address DEPTH-1.
  - The reset state is FILL if FILL_ON_RESET=1, else IDLE.
- FILL:
  - Writes the latched fill word to address 0,1,...,DEPTH-1, one per cycle: exactly DEPTH cycles, busy high throughout.
  - busy drops in the cycle after the last write.
  - The word is fill_data for a requested fill, FILL_VALUE for a reset fill.
  - fill_req during FILL is ignored (no restart, no queueing).
- Write port:
  - wr_ready = (state==IDLE).
  - A beat is accepted when wr_valid & wr_ready, and the RAM is written that cycle.
  - Direct mode (wr_auto=0): address = wr_addr; the pointer is unchanged.
  - Auto mode: address = wr_first ? wr_addr : pointer. After the beat, pointer <= address+1 mod DEPTH (DEPTH-1 wraps to 0).
  - fill_req and wr_valid in the same IDLE cycle: the fill wins, the write is not accepted, and wr_ready is 0 from the next cycle.
- Read port:
  - Always serviced, including during FILL.
  - RD_LAT=1: rd_data registered from the array one cycle after rd_en.
  - RD_LAT=2: an extra output register is added.
  - rd_valid is rd_en delayed RD_LAT cycles.
  - rd_data holds its last value when no read completes.
  - Read and write to the same address in the same cycle: read-first (returns the old word).
- Reset asserted mid-fill or mid-burst: the FSM, pointer, counter and outputs return immediately to their reset values. Array contents are undefined (partially written).
- Widths: the pointer and fill counter are ADDR_W bits and wrap naturally. There are no width conversions on data.

Decomposition:
- Shared package vga_pkg holds:
  - PIX_W=12 and TILE_DIM=16;
  - TILE_RAM_AW=12;
  - fill FSM state enum (ST_IDLE, ST_FILL).
- One sub-module, vga_tile_ram_core: a plain DATA_W x DEPTH array with one write port and one sync-read port (read-first), mapping to distributed or block RAM. The wrapper holds the FSM, pointer, write mux and read pipeline.

Test Plan:
- Reset fill, FILL_ON_RESET=1, FILL_VALUE=12'h000: release rst_n -> busy high exactly 4096 cycles, wr_ready=0 meanwhile; then reads of addr 0, 2047, 4095 return 12'h000.
- Auto burst: wr_first=1 with wr_addr=12'hFFE, then 4 beats of data A,B,C,D -> addresses FFE, FFF, 000, 001 hold A..D (pointer wrap checked).
- Direct write then read: write 12'hF0F to 12'h123, then rd_en at 12'h123 -> rd_data=12'hF0F with rd_valid exactly RD_LAT cycles later; run with RD_LAT=1 and RD_LAT=2.
- Collision: same-cycle write 12'hABC and read at 12'h010, where the old value is 12'h111 -> rd_data=12'h111; next read returns 12'hABC.
- fill_req with fill_data=12'h00F in the same cycle as wr_valid -> write not accepted; after 4096 cycles every sampled address reads 12'h00F; a second fill_req mid-fill does not extend busy.
- Reset at fill cycle 100 -> busy, rd_valid and rd_data go to reset values asynchronously; after release, a new reset fill completes in 4096 cycles.
